// File: rtl/audio_pkg.sv
// audio_pkg: sample width, stereo frame layout and capture FSM states shared by the audio paths
package audio_pkg;
  localparam int SAMPLE_W = 16;
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SYNC, ST_LEFT, ST_RIGHT} rx_state_e;
endpackage

// File: rtl/audio_rx_fifo.sv
// audio_rx_fifo: single-clock frame FIFO with registered read, fill count and full/empty flags
module audio_rx_fifo
  import audio_pkg::*;
#(
  parameter int FIFO_AW = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  frame_t           din,
  input  logic             pop,
  output frame_t           dout,
  output logic             dout_valid,
  output logic [FIFO_AW:0] fill,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << FIFO_AW;
  frame_t mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = fill == (FIFO_AW+1)'(DEPTH);
  assign empty = fill == '0;
  assign do_pop = pop & ~empty;
  // a pop in the same cycle frees the slot that a push into a full FIFO needs
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk_sys)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout <= mem[rd_ptr];
      end
      fill <= fill + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    end
endmodule

// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: oversampled I2S receiver packing 16-bit stereo frames into a CPU-readable FIFO
module i2s_rx_capture
  import audio_pkg::*;
#(
  parameter int FIFO_AW = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             i2s_sclk,
  input  logic             i2s_lrck,
  input  logic             i2s_adc,
  input  logic             capture_en,
  input  logic             audio_bus_rd,
  output logic [31:0]      audio_bus_out,
  output logic             audio_bus_out_valid,
  output logic [FIFO_AW:0] audio_buffer_fill,
  input  logic             overflow_clr,
  output logic             overflow
);
  logic [2:0] sclk_s, lrck_s, adc_s;
  logic sclk_rise, lrck, sdata, lrck_prev, lrck_chg, lr_fall, lr_rise;
  logic [4:0] bit_cnt;
  logic [3:0] bit_idx;
  logic [SAMPLE_W-1:0] sreg, left_word;
  rx_state_e state;
  logic push, full, empty, drop;
  frame_t push_frame, fifo_dout;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      sclk_s <= '0;
      lrck_s <= '0;
      adc_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], i2s_sclk};
      lrck_s <= {lrck_s[1:0], i2s_lrck};
      adc_s <= {adc_s[1:0], i2s_adc};
    end
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign lrck = lrck_s[2];
  assign sdata = adc_s[2];
  assign lrck_chg = lrck != lrck_prev;
  assign lr_fall = sclk_rise & lrck_chg & ~lrck;
  assign lr_rise = sclk_rise & lrck_chg & lrck;
  assign bit_idx = 4'(SAMPLE_W - 1) - bit_cnt[3:0];
  // bits land MSB-first at fixed positions, so a short word stays left-justified with zero LSBs
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      lrck_prev <= 1'b0;
      bit_cnt <= '0;
      sreg <= '0;
    end else if (sclk_rise) begin
      lrck_prev <= lrck;
      if (lrck_chg) begin
        bit_cnt <= '0;
        sreg <= '0;
      end else if (!bit_cnt[4]) begin
        sreg[bit_idx] <= sdata;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      left_word <= '0;
      push <= 1'b0;
      push_frame <= '0;
    end else begin
      push <= 1'b0;
      if (!capture_en) state <= ST_IDLE;
      else
        case (state)
          ST_IDLE: state <= ST_WAIT_SYNC;
          ST_WAIT_SYNC: if (lr_fall) state <= ST_LEFT;
          ST_LEFT:
            if (lr_rise) begin
              left_word <= sreg;
              state <= ST_RIGHT;
            end
          ST_RIGHT:
            if (lr_fall) begin
              push <= 1'b1;
              push_frame <= '{left: left_word, right: sreg};
              state <= ST_LEFT;
            end
          default: state <= ST_IDLE;
        endcase
    end
  assign drop = push & full & ~(audio_bus_rd & ~empty);
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) overflow <= 1'b0;
    else overflow <= drop | (overflow & ~overflow_clr);
  audio_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .push(push),
    .din(push_frame),
    .pop(audio_bus_rd),
    .dout(fifo_dout),
    .dout_valid(audio_bus_out_valid),
    .fill(audio_buffer_fill),
    .full(full),
    .empty(empty)
  );
  assign audio_bus_out = fifo_dout;
endmodule

// File: tb/tb_i2s_rx_capture.sv
// tb_i2s_rx_capture: directed I2S stimulus with hand-computed frames, small FIFO to reach full/overflow
module tb_i2s_rx_capture;
  logic clk_sys = 1'b0, reset_n = 1'b0;
  logic i2s_sclk = 1'b0, i2s_lrck = 1'b1, i2s_adc = 1'b0;
  logic capture_en = 1'b0, audio_bus_rd = 1'b0, overflow_clr = 1'b0;
  logic [31:0] audio_bus_out;
  logic audio_bus_out_valid, overflow;
  logic [2:0] audio_buffer_fill;
  int total = 0, passed = 0, fails = 0, vcnt = 0, vsnap;

  i2s_rx_capture #(.FIFO_AW(2)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .i2s_sclk(i2s_sclk),
    .i2s_lrck(i2s_lrck),
    .i2s_adc(i2s_adc),
    .capture_en(capture_en),
    .audio_bus_rd(audio_bus_rd),
    .audio_bus_out(audio_bus_out),
    .audio_bus_out_valid(audio_bus_out_valid),
    .audio_buffer_fill(audio_buffer_fill),
    .overflow_clr(overflow_clr),
    .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) if (audio_bus_out_valid) vcnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one bit slot: data/LRCK change with SCLK low, SCLK rises mid-slot (SCLK = clk_sys/8)
  task automatic slot(input logic lr, input logic d);
    i2s_sclk = 1'b0;
    i2s_lrck = lr;
    i2s_adc = d;
    #40;
    i2s_sclk = 1'b1;
    #40;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(1'b1, 1'b0);
  endtask

  // 32 slots per channel; slot 0 of each channel is the 1-bit I2S delay, slots 1..16 carry MSB..LSB
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int en_at = -1, input int dis_at = -1);
    logic [15:0] w;
    int k;
    for (int i = 0; i < 64; i++) begin
      if (i == en_at) capture_en = 1'b1;
      if (i == dis_at) capture_en = 1'b0;
      w = (i < 32) ? l : r;
      k = i % 32;
      slot(i >= 32, (k >= 1 && k <= 16) ? w[16-k] : 1'b0);
    end
  endtask

  task automatic close_stream();
    slot(1'b0, 1'b0);
    #80;
    capture_en = 1'b0;
    idle(2);
  endtask

  task automatic rd(input string tag, input logic [31:0] exp);
    audio_bus_rd = 1'b1;
    #10;
    audio_bus_rd = 1'b0;
    chk({tag, "_valid"}, 32'(audio_bus_out_valid), 32'd1);
    chk(tag, audio_bus_out, exp);
    #10;
    chk({tag, "_pulse_end"}, 32'(audio_bus_out_valid), 32'd0);
  endtask

  initial begin
    #20 reset_n = 1'b1;
    #10;
    chk("rst_fill", 32'(audio_buffer_fill), 32'd0);
    chk("rst_valid", 32'(audio_bus_out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_out", audio_bus_out, 32'd0);

    idle(2);
    frame(16'h1234, 16'hABCD);
    close_stream();
    chk("idle_fill", 32'(audio_buffer_fill), 32'd0);
    chk("idle_overflow", 32'(overflow), 32'd0);
    chk("idle_valid_cnt", 32'(vcnt), 32'd0);

    capture_en = 1'b1;
    idle(2);
    frame(16'h1234, 16'hABCD);
    frame(16'h8000, 16'h7FFF);
    close_stream();
    chk("basic_fill", 32'(audio_buffer_fill), 32'd2);
    rd("basic_rd0", 32'h1234ABCD);
    rd("basic_rd1", 32'h80007FFF);
    chk("basic_fill_after", 32'(audio_buffer_fill), 32'd0);
    vsnap = vcnt;
    audio_bus_rd = 1'b1;
    #10;
    audio_bus_rd = 1'b0;
    #10;
    chk("empty_rd_valid", 32'(audio_bus_out_valid), 32'd0);
    chk("empty_rd_hold", audio_bus_out, 32'h80007FFF);
    chk("empty_rd_cnt", 32'(vcnt - vsnap), 32'd0);
    chk("empty_rd_fill", 32'(audio_buffer_fill), 32'd0);

    frame(16'h1111, 16'h2222, 40);
    frame(16'h3333, 16'h4444);
    close_stream();
    chk("midenable_fill", 32'(audio_buffer_fill), 32'd1);
    rd("midenable_rd", 32'h33334444);

    capture_en = 1'b1;
    idle(2);
    frame(16'h5555, 16'h6666, 40, 10);
    frame(16'h7777, 16'h8888);
    close_stream();
    chk("disable_fill", 32'(audio_buffer_fill), 32'd1);
    rd("disable_rd", 32'h77778888);

    capture_en = 1'b1;
    idle(2);
    frame(16'hA001, 16'h0B01);
    frame(16'hA002, 16'h0B02);
    frame(16'hA003, 16'h0B03);
    frame(16'hA004, 16'h0B04);
    frame(16'hA005, 16'h0B05);
    close_stream();
    chk("ovf_fill", 32'(audio_buffer_fill), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    rd("ovf_rd0", 32'hA0010B01);
    rd("ovf_rd1", 32'hA0020B02);
    rd("ovf_rd2", 32'hA0030B03);
    rd("ovf_rd3", 32'hA0040B04);
    chk("ovf_fill_after", 32'(audio_buffer_fill), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    #10;
    overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    capture_en = 1'b1;
    idle(2);
    frame(16'hC001, 16'h0D01);
    frame(16'hC002, 16'h0D02);
    frame(16'hC003, 16'h0D03);
    frame(16'hC004, 16'h0D04);
    frame(16'hC005, 16'h0D05);
    // closing slot: SCLK rise at +40, detect at +55, push registered at +65, write at +75
    i2s_sclk = 1'b0;
    i2s_lrck = 1'b0;
    i2s_adc = 1'b0;
    #40;
    i2s_sclk = 1'b1;
    #30;
    audio_bus_rd = 1'b1;
    #10;
    audio_bus_rd = 1'b0;
    chk("fullpop_valid", 32'(audio_bus_out_valid), 32'd1);
    chk("fullpop_out", audio_bus_out, 32'hC0010D01);
    #80;
    capture_en = 1'b0;
    idle(2);
    chk("fullpop_fill", 32'(audio_buffer_fill), 32'd4);
    chk("fullpop_overflow", 32'(overflow), 32'd0);
    rd("fullpop_rd0", 32'hC0020D02);
    rd("fullpop_rd1", 32'hC0030D03);
    rd("fullpop_rd2", 32'hC0040D04);
    rd("fullpop_rd3", 32'hC0050D05);
    chk("fullpop_fill_after", 32'(audio_buffer_fill), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
